// File: rtl/decd_pkg.sv
// Shared definitions for the registered N-to-2^N decoder (decd_n2m_seq).
// Holds the operating-state encoding and the mode select constants.
package decd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage : decd_pkg

// File: rtl/decd_tick_div.sv
// SCAN-step prescaler for decd_n2m_seq.
// Produces a one-cycle tick every DIV cycles while run is high.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   clr   - synchronous clear of the cycle counter (wins over run)
//   run   - count enable
//   tick  - high in the last cycle of each DIV-cycle period while running
module decd_tick_div
  import decd_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CntLast = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // With DIV = 1 CntLast is zero, so tick follows run every cycle.
  assign tick = run && (cnt_q == CntLast);

  // Counter walks 0..DIV-1 and wraps; clear has priority so a fresh
  // scan always starts a full DIV-cycle period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : decd_tick_div

// File: rtl/decd_n2m_seq.sv
// Registered N-to-2^N one-hot decoder with DIRECT and SCAN modes.
// DIRECT decodes in_sel whenever in_valid is high; SCAN walks the outputs
// 0..last_sel, advancing one index every DIV cycles.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   en          - block enable, low forces IDLE (cleared outputs)
//   mode        - 0 = DIRECT, 1 = SCAN
//   in_valid    - qualifies in_sel in DIRECT
//   in_sel      - index to decode in DIRECT
//   last_sel    - highest index visited in SCAN
//   out_onehot  - registered decoded output (2^N bits)
//   out_idx     - index currently asserted
//   out_valid   - out_onehot holds a decoded value
// Build option: define DECD_OUT_INV_EN for one-cold out_onehot (active-low
// anode drives); the idle/reset value then becomes all ones.
module decd_n2m_seq
  import decd_pkg::*;
#(
  parameter int N   = 3,
  parameter int DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic                in_valid,
  input  logic [N-1:0]        in_sel,
  input  logic [N-1:0]        last_sel,
  output logic [(1<<N)-1:0]   out_onehot,
  output logic [N-1:0]        out_idx,
  output logic                out_valid
);

  localparam int W = 1 << N;

`ifdef DECD_OUT_INV_EN
  localparam logic [W-1:0] IdleOnehot = '1;
`else
  localparam logic [W-1:0] IdleOnehot = '0;
`endif

  state_e         state_q, state_d;
  logic [N-1:0]   idx_q, idx_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   onehot_q, onehot_d;
  logic [W-1:0]   decoded;
  logic           scanHold;
  logic           tick;

  // The state simply follows en/mode each cycle; en dominates mode.
  always_comb begin
    state_d = ST_IDLE;
    if (en) begin
      state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
    end
  end

  // scanHold marks a cycle that continues an existing scan; any other cycle
  // keeps the prescaler at zero so a new scan gets a full first period.
  assign scanHold = (state_q == ST_SCAN) && (state_d == ST_SCAN);

  decd_tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!scanHold),
    .run   (state_q == ST_SCAN),
    .tick  (tick)
  );

  // Index/valid next-state. Decisions use state_d so a mode change takes
  // effect at the same edge that samples it.
  always_comb begin
    idx_d   = idx_q;
    valid_d = valid_q;
    case (state_d)
      ST_DIRECT: begin
        if (in_valid) begin
          idx_d   = in_sel;
          valid_d = 1'b1;
        end
      end
      ST_SCAN: begin
        if (!scanHold) begin
          idx_d   = '0;
          valid_d = 1'b1;
        end else if (tick) begin
          // >= rather than == so lowering last_sel below idx wraps at once.
          idx_d = (idx_q >= last_sel) ? '0 : idx_q + N'(1);
        end
      end
      default: begin
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Decode from the next-state index so the one-hot register lines up
  // with out_idx/out_valid on the same edge.
  always_comb begin
    decoded = valid_d ? (W'(1) << idx_d) : '0;
`ifdef DECD_OUT_INV_EN
    onehot_d = ~decoded;
`else
    onehot_d = decoded;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      onehot_q <= IdleOnehot;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      onehot_q <= onehot_d;
    end
  end

  assign out_onehot = onehot_q;
  assign out_idx    = idx_q;
  assign out_valid  = valid_q;

endmodule : decd_n2m_seq
